// File: rtl/key_debounce.sv
// key_debounce: synchronises a raw push-button and emits a debounced level plus press/release strobes
module key_debounce #(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int ACTIVE_LOW      = 1
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic key_raw_i,
    output logic key_o,
    output logic press_pulse_o,
    output logic release_pulse_o
);
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic REL_LVL = (ACTIVE_LOW != 0);
    localparam logic [1:0] IDLE       = 2'd0;
    localparam logic [1:0] CONF_PRESS = 2'd1;
    localparam logic [1:0] PRESSED    = 2'd2;
    localparam logic [1:0] CONF_REL   = 2'd3;

    logic [1:0]       sync;
    logic [1:0]       state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic             s, done, press_n, rel_n;

    assign s    = sync[1] ^ REL_LVL;
    assign done = cnt == LAST;

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        press_n = 1'b0;
        rel_n   = 1'b0;
        case (state)
            IDLE: if (s) begin
                state_n = CONF_PRESS;
                cnt_n   = '0;
            end
            CONF_PRESS: if (!s) state_n = IDLE;
                else if (done) begin
                    state_n = PRESSED;
                    press_n = 1'b1;
                end else cnt_n = cnt + 1'b1;
            PRESSED: if (!s) begin
                state_n = CONF_REL;
                cnt_n   = '0;
            end
            default: if (s) state_n = PRESSED;
                else if (done) begin
                    state_n = IDLE;
                    rel_n   = 1'b1;
                end else cnt_n = cnt + 1'b1;
        endcase
    end

    // PRESSED and CONF_REL share bit 1, so key_o is simply that bit of the next state
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync            <= {2{REL_LVL}};
            state           <= IDLE;
            cnt             <= '0;
            key_o           <= 1'b0;
            press_pulse_o   <= 1'b0;
            release_pulse_o <= 1'b0;
        end else begin
            sync            <= {sync[0], key_raw_i};
            state           <= state_n;
            cnt             <= cnt_n;
            key_o           <= state_n[1];
            press_pulse_o   <= press_n;
            release_pulse_o <= rel_n;
        end
    end
endmodule

// File: tb/tb_key_debounce.sv
// tb_key_debounce: directed stimulus with a queue of expected press/release events checked every cycle
module tb_key_debounce;
    logic clk = 1'b0;
    logic rst_i, key_raw_i;
    logic key_o, press_pulse_o, release_pulse_o;
    int   cyc = 0;
    int   tests = 0;
    int   fails = 0;
    logic mon_en = 1'b0;
    logic exp_key = 1'b0;

    typedef struct {
        logic rel;
        int   cyc;
    } ev_t;
    ev_t q[$];

    key_debounce #(.DEBOUNCE_CYCLES(4), .ACTIVE_LOW(1)) dut (
        .clk_i(clk),
        .rst_i(rst_i),
        .key_raw_i(key_raw_i),
        .key_o(key_o),
        .press_pulse_o(press_pulse_o),
        .release_pulse_o(release_pulse_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check();
        logic ep, er;
        ep = 1'b0;
        er = 1'b0;
        if (q.size() > 0 && q[0].cyc == cyc) begin
            ep      = !q[0].rel;
            er      = q[0].rel;
            exp_key = !q[0].rel;
            void'(q.pop_front());
        end
        tests++;
        assert (press_pulse_o === ep) else begin
            fails++;
            $error("FAIL press_pulse cyc=%0d got %b exp %b", cyc, press_pulse_o, ep);
        end
        tests++;
        assert (release_pulse_o === er) else begin
            fails++;
            $error("FAIL release_pulse cyc=%0d got %b exp %b", cyc, release_pulse_o, er);
        end
        tests++;
        assert (key_o === exp_key) else begin
            fails++;
            $error("FAIL key_o cyc=%0d got %b exp %b", cyc, key_o, exp_key);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(negedge clk);
            if (mon_en) check();
            #1;
        end
    endtask

    // first sampling edge is cyc+1; the strobe follows 6 edges later
    task automatic drive(input logic v, input logic expect_ev, input logic rel);
        key_raw_i = v;
        if (expect_ev) q.push_back('{rel: rel, cyc: cyc + 7});
    endtask

    initial begin
        rst_i     = 1'b1;
        key_raw_i = 1'b1;
        tick(3);
        tests++;
        assert (key_o === 1'b0) else begin
            fails++;
            $error("FAIL reset_key got %b exp 0", key_o);
        end
        tests++;
        assert ({press_pulse_o, release_pulse_o} === 2'b00) else begin
            fails++;
            $error("FAIL reset_pulses got %b exp 00", {press_pulse_o, release_pulse_o});
        end
        rst_i  = 1'b0;
        mon_en = 1'b1;
        tick(50);
        drive(1'b0, 1'b1, 1'b0);
        tick(20);
        drive(1'b1, 1'b1, 1'b1);
        tick(20);
        drive(1'b0, 1'b0, 1'b0);
        tick(2);
        drive(1'b1, 1'b0, 1'b0);
        tick(2);
        drive(1'b0, 1'b0, 1'b0);
        tick(2);
        drive(1'b1, 1'b0, 1'b0);
        tick(2);
        drive(1'b0, 1'b1, 1'b0);
        tick(20);
        drive(1'b1, 1'b0, 1'b0);
        tick(3);
        drive(1'b0, 1'b0, 1'b0);
        tick(20);
        drive(1'b1, 1'b1, 1'b1);
        tick(20);
        drive(1'b0, 1'b1, 1'b0);
        tick(20);
        rst_i   = 1'b1;
        exp_key = 1'b0;
        q.delete();
        tick(3);
        rst_i = 1'b0;
        q.push_back('{rel: 1'b0, cyc: cyc + 7});
        tick(20);
        drive(1'b1, 1'b1, 1'b1);
        tick(20);
        tests++;
        assert (q.size() == 0) else begin
            fails++;
            $error("FAIL pending_events got %0d exp 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
